// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the M-extension unit.
// Holds op codes (funct3), FSM states and the counter-width helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int xlen_log2(input int xlen);
    return (xlen <= 2) ? 1 : $clog2(xlen);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative radix-2 restoring unsigned divider.
// Ports: clk, rst, i_start, i_abort, i_dividend, i_divisor -> o_done, o_quo, o_rem.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  localparam int CW = xlen_log2(XLEN);

  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // Partial remainder shifted left with the next dividend bit;
  // a borrow (MSB set) means the trial subtraction is rejected.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      if (w_diff[XLEN]) r_rem <= w_shift[XLEN-1:0];
      else              r_rem <= w_diff[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(XLEN-1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension unit, pipelined multiply + iterative divide.
// Ports: in_* request handshake, out_* result handshake, flush, busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = xlen_log2(XLEN);
  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_next;

  logic             w_accept, w_is_div, w_sdiv, w_fast;
  logic             w_b_zero, w_ovf, w_a_neg, w_b_neg;
  logic             w_a_sx, w_b_sx, w_mul_last, w_div_done;
  logic [XLEN-1:0]  w_abs_a, w_abs_b, w_fast_res;
  logic [XLEN-1:0]  w_mul_res, w_div_res, w_quo, w_rem;
  logic [PW-1:0]    w_a_ext, w_b_ext, w_prod;
  logic [PW-1:0]    r_pipe [MUL_STAGES];
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag, r_out_tag;
  logic [XLEN-1:0]  r_out_data;
  logic             r_neg_q, r_neg_r;
  logic [CW-1:0]    r_cnt;

  assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_is_div = in_op[2];
  assign w_sdiv   = in_op[2] & ~in_op[0];
  assign w_a_neg  = w_sdiv & in_a[XLEN-1];
  assign w_b_neg  = w_sdiv & in_b[XLEN-1];
  assign w_abs_a  = w_a_neg ? -in_a : in_a;
  assign w_abs_b  = w_b_neg ? -in_b : in_b;
  assign w_b_zero = (in_b == '0);
  assign w_ovf    = w_sdiv && (in_a == MIN_NEG) && (in_b == '1);
  assign w_fast   = w_b_zero | w_ovf;

  // op[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
  always_comb begin
    w_fast_res = '0;
    if (w_b_zero) w_fast_res = in_op[1] ? in_a : '1;
    else          w_fast_res = in_op[1] ? '0 : in_a;
  end

  // Sign-extending to the full product width keeps the low
  // 2*XLEN bits exact for every signed/unsigned mix.
  assign w_a_sx  = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign w_b_sx  = (in_op == OP_MULH);
  assign w_a_ext = {{XLEN{w_a_sx & in_a[XLEN-1]}}, in_a};
  assign w_b_ext = {{XLEN{w_b_sx & in_b[XLEN-1]}}, in_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_mul_res = (r_op == OP_MUL) ? r_pipe[MUL_STAGES-1][XLEN-1:0]
                                      : r_pipe[MUL_STAGES-1][PW-1:XLEN];
  assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem : w_rem)
                             : (r_neg_q ? -w_quo : w_quo);
  assign w_mul_last = (r_cnt == CW'(MUL_STAGES-1));

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept & w_is_div & ~w_fast),
    .i_abort   (flush),
    .i_dividend(w_abs_a),
    .i_divisor (w_abs_b),
    .o_done    (w_div_done),
    .o_quo     (w_quo),
    .o_rem     (w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_accept)
          w_next = !w_is_div ? ST_MUL : (w_fast ? ST_DONE : ST_DIV);
      ST_MUL:
        if (flush)           w_next = ST_IDLE;
        else if (w_mul_last) w_next = ST_DONE;
      ST_DIV:
        if (flush)           w_next = ST_IDLE;
        else if (w_div_done) w_next = ST_DONE;
      ST_DONE:
        if (flush || out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = r_out_data;
  assign out_tag  = r_out_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) r_pipe[i] <= '0;
    end else begin
      if (w_accept && !w_is_div) r_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_tag      <= '0;
      r_out_tag  <= '0;
      r_out_data <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= in_op;
        r_tag   <= in_tag;
        r_cnt   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        if (w_is_div && w_fast) begin
          r_out_data <= w_fast_res;
          r_out_tag  <= in_tag;
        end
      end
      if (r_state == ST_MUL) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_mul_last && !flush) begin
          r_out_data <= w_mul_res;
          r_out_tag  <= r_tag;
        end
      end
      if (r_state == ST_DIV && w_div_done && !flush) begin
        r_out_data <= w_div_res;
        r_out_tag  <= r_tag;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised successor to the single-cycle-multiply / external-divide M-extension wrapper.
- Executes all eight RV M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a configurable XLEN.
- Multiplier is pipelined to a configurable depth; the divider is an iterative radix-2 restoring core.
- Sits in the EX stage beside the ALU. Uses a valid/ready handshake on both sides, carries a destination tag, and supports pipeline flush.

Parameters:
XLEN, 32, operand/result width (32 or 64).
MUL_STAGES, 2, multiplier latency in cycles (1..4).
TAG_W, 5, width of the pass-through tag (rd index).

Ports:
clk  in  1  clock.
rst  in  1  reset.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request.
in_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
in_a  in  XLEN  rs1 operand.
in_b  in  XLEN  rs2 operand.
in_tag  in  TAG_W  destination tag.
flush  in  1  kill any in-flight operation.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  XLEN  result.
out_tag  out  TAG_W  tag of the result.
busy  out  1  an operation is in flight or a result is held.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_tag=0, busy=0, counter=0.
- Single outstanding operation.
  - in_ready=1 only in IDLE.
  - A request is accepted on the edge where in_valid && in_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on accept with op<4.
  - IDLE -> DIV on accept with op>=4 and the normal path.
  - IDLE -> DONE on accept with op>=4 and a special case (fast path).
  - MUL -> DONE when the stage counter reaches MUL_STAGES-1.
  - DIV -> DONE when the bit counter reaches XLEN-1.
  - DONE -> IDLE on out_ready.
- Latency, counted from the accept edge: out_valid rises after MUL_STAGES+1 edges for multiply, XLEN+2 edges for normal divide, and 1 edge for the fast path.
- Multiply:
  - Form a 2*XLEN product from (XLEN+1)-bit sign-extended operands.
  - Sign rules: MULH both signed; MULHSU a signed, b unsigned; MULHU and MUL both unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - Register the product through MUL_STAGES pipeline registers.
- Divide:
  - Signed ops take absolute values at accept.
  - Restoring shift-subtract, one quotient bit per cycle, XLEN iterations.
  - Apply the sign fix in the final cycle: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Fast path, decided at accept:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
- Output hold: in DONE, out_valid, out_data and out_tag stay stable until out_ready. out_ready while out_valid=0 is ignored.
- Flush:
  - In MUL or DIV: return to IDLE next edge, no result produced.
  - In DONE: drop the held result (out_valid=0 next edge).
  - flush && in_valid in IDLE: the request is NOT accepted.
  - flush overrides out_ready.
- No back-to-back accept: after DONE->IDLE, in_ready rises the edge after the handshake, giving a 1-cycle bubble.
- busy = (state != IDLE).
- An asynchronous reset mid-operation returns all state to reset values immediately; partial results are discarded.

Decomposition:
- Shared package: op encodings (OP_MUL..OP_REMU), FSM state encodings, and helper constants for XLEN-dependent widths (XLEN_LOG2 for the counter).
- Sub-module muldiv_div_core: iterative radix-2 divider with start/done, unsigned XLEN operands, and quotient/remainder outputs.
- The multiply pipeline and FSM stay in the top module.

Test Plan:
MULH 0x80000000 x 0x80000000 (XLEN=32, MUL_STAGES=2) -> out_data=0x40000000, out_valid on the 3rd edge after accept; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE.
DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2, each after 34 edges.
DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7, both after 1 edge; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, after 1 edge.
Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid/out_data/out_tag stable, in_ready=0; then out_ready=1 -> out_valid=0 next edge, in_ready=1.
Flush at iteration 10 of DIV with tag 5 -> no out_valid ever for tag 5; IDLE next edge; a following MUL 3x4, tag 6 -> out_data=12, out_tag=6.
Assert rst during DIV iteration 20 -> out_valid=0, in_ready=1, busy=0 immediately (asynchronously); after release, DIVU 9/3 -> 3.
